mac_node: RTL and testbench

//  Parametrised neuron node: out = sat(act((bias + sum_i x[i]*w[i]) >>> SHIFT)).

---
 rtl/mac_node.sv | 121 ++++++++++++
 tb/tb_mac_node.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mac_node.sv
// Parametrised neuron node: out = sat(act((bias + sum x[i]*w[i]) >>> SHIFT)),
// evaluated with one time-multiplexed signed multiplier behind valid/ready handshakes.
module mac_node #(
  parameter int DATA_W  = 8,
  parameter int N_IN    = 2,
  parameter int SHIFT   = 0,
  parameter int RELU_EN = 0,
  parameter int ACC_W   = 2*DATA_W + $clog2(N_IN) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_IN*DATA_W-1:0]   in_data,
  input  logic [N_IN*DATA_W-1:0]   in_weight,
  input  logic [DATA_W-1:0]        in_bias,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_sat
);

  localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_IN - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DATA_W-1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                   state;
  logic [N_IN*DATA_W-1:0]   x_p0;
  logic [N_IN*DATA_W-1:0]   w_p0;
  logic signed [ACC_W-1:0]  acc_p1;
  logic signed [ACC_W-1:0]  acc_nxt;
  logic [IDX_W-1:0]         idx_p1;
  logic signed [DATA_W-1:0] x_sel;
  logic signed [DATA_W-1:0] w_sel;
  logic signed [2*DATA_W-1:0] prod;
  logic [DATA_W:0]          res;

  function automatic logic signed [ACC_W-1:0] shift_act(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    s = a >>> SHIFT;
    if ((RELU_EN != 0) && s[ACC_W-1])
      s = '0;
    return s;
  endfunction

  // Returns {clipped, value}.
  function automatic logic [DATA_W:0] saturate(input logic signed [ACC_W-1:0] s);
    if (s > SAT_MAX)
      return {1'b1, SAT_MAX[DATA_W-1:0]};
    if (s < SAT_MIN)
      return {1'b1, SAT_MIN[DATA_W-1:0]};
    return {1'b0, s[DATA_W-1:0]};
  endfunction

  // Stage p0: operand capture at the accepting edge.
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      x_p0 <= in_data;
      w_p0 <= in_weight;
    end
  end

  // Stage p1: one product per cycle into the accumulator; the result path taps the
  // post-add value so the final term's edge can register the output directly.
  always_comb begin
    x_sel   = $signed(x_p0[idx_p1*DATA_W +: DATA_W]);
    w_sel   = $signed(w_p0[idx_p1*DATA_W +: DATA_W]);
    prod    = {{DATA_W{x_sel[DATA_W-1]}}, x_sel} * {{DATA_W{w_sel[DATA_W-1]}}, w_sel};
    acc_nxt = acc_p1 + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    res     = saturate(shift_act(acc_nxt));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      acc_p1    <= '0;
      idx_p1    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc_p1   <= {{(ACC_W-DATA_W){in_bias[DATA_W-1]}}, in_bias};
            idx_p1   <= '0;
            in_ready <= 1'b0;
            state    <= MAC;
          end
        end
        MAC: begin
          acc_p1 <= acc_nxt;
          idx_p1 <= idx_p1 + 1'b1;
          if (idx_p1 == LAST_IDX) begin
            out_data  <= res[DATA_W-1:0];
            out_sat   <= res[DATA_W];
            out_valid <= 1'b1;
            state     <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_node.sv
// Bench for mac_node: three configurations (plain, ReLU, SHIFT=4) driven in lockstep,
// expected results queued at each accept and checked by an independent monitor.
module tb_mac_node;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] in_data = '0;
  logic [15:0] in_weight = '0;
  logic [7:0]  in_bias = '0;
  logic [2:0]  rdy;
  logic [2:0]  ov;
  logic [2:0]  os;
  logic [7:0]  od [3];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit seen = 0;
  bit rand_rdy = 0;

  typedef struct {
    int          t;
    logic [23:0] d;
    logic [2:0]  s;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mac_node #(.DATA_W(8), .N_IN(2), .SHIFT(0), .RELU_EN(0)) u_base (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]), .in_data(in_data),
    .in_weight(in_weight), .in_bias(in_bias), .out_valid(ov[0]), .out_ready(out_ready),
    .out_data(od[0]), .out_sat(os[0]));

  mac_node #(.DATA_W(8), .N_IN(2), .SHIFT(0), .RELU_EN(1)) u_relu (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]), .in_data(in_data),
    .in_weight(in_weight), .in_bias(in_bias), .out_valid(ov[1]), .out_ready(out_ready),
    .out_data(od[1]), .out_sat(os[1]));

  mac_node #(.DATA_W(8), .N_IN(2), .SHIFT(4), .RELU_EN(0)) u_shft (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]), .in_data(in_data),
    .in_weight(in_weight), .in_bias(in_bias), .out_valid(ov[2]), .out_ready(out_ready),
    .out_data(od[2]), .out_sat(os[2]));

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic; >>> on int floors toward -inf.
  function automatic logic [8:0] model(input int x0, input int x1, input int w0, input int w1,
                                       input int b, input int sh, input bit relu);
    int s;
    s = (b + x0*w0 + x1*w1) >>> sh;
    if (relu && s < 0) s = 0;
    if (s > 127) return {1'b1, 8'd127};
    if (s < -128) return {1'b1, 8'h80};
    return {1'b0, 8'(s)};
  endfunction

  task automatic push_exp();
    exp_t e;
    logic [8:0] r;
    int x0, x1, w0, w1, b;
    x0 = $signed(in_data[7:0]);    x1 = $signed(in_data[15:8]);
    w0 = $signed(in_weight[7:0]);  w1 = $signed(in_weight[15:8]);
    b  = $signed(in_bias);
    e.t = cyc + 1;
    r = model(x0, x1, w0, w1, b, 0, 1'b0); e.d[7:0]   = r[7:0]; e.s[0] = r[8];
    r = model(x0, x1, w0, w1, b, 0, 1'b1); e.d[15:8]  = r[7:0]; e.s[1] = r[8];
    r = model(x0, x1, w0, w1, b, 4, 1'b0); e.d[23:16] = r[7:0]; e.s[2] = r[8];
    q.push_back(e);
  endtask

  // An accept happens at the next rising edge whenever both are high here.
  always @(negedge clk) begin
    if (!rst && in_valid && rdy[0]) push_exp();
  end

  always @(negedge clk) begin
    if (!rst && ov[0]) begin
      if (q.size() == 0) begin
        chk("spurious_out_valid", 1, 0);
      end else begin
        for (int k = 0; k < 3; k++) begin
          chk($sformatf("out_valid_%0d", k), int'(ov[k]), 1);
          chk($sformatf("out_data_%0d", k), int'(od[k]), int'(q[0].d[k*8 +: 8]));
          chk($sformatf("out_sat_%0d", k), int'(os[k]), int'(q[0].s[k]));
          chk($sformatf("in_ready_busy_%0d", k), int'(rdy[k]), 0);
        end
        if (!seen) begin
          chk("latency", cyc, q[0].t + 2);
          seen = 1;
        end
        if (out_ready) begin
          void'(q.pop_front());
          seen = 0;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1 out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input logic [7:0] x0, input logic [7:0] x1, input logic [7:0] w0,
                      input logic [7:0] w1, input logic [7:0] b);
    bit got;
    @(posedge clk); #1;
    in_data = {x1, x0}; in_weight = {w1, w0}; in_bias = b; in_valid = 1'b1;
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (rdy[0]) got = 1;
    end
    if (!got) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data = 16'($urandom); in_weight = 16'($urandom); in_bias = 8'($urandom);
  endtask

  task automatic drain();
    bit done;
    done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !ov[0]) done = 1;
    end
    if (!done) chk("drain_timeout", q.size(), 0);
  endtask

  function automatic logic [7:0] pick();
    case ($urandom_range(0, 5))
      0: return 8'h80;
      1: return 8'h7f;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_in_ready_%0d", k), int'(rdy[k]), 1);
      chk($sformatf("rst_out_valid_%0d", k), int'(ov[k]), 0);
      chk($sformatf("rst_out_data_%0d", k), int'(od[k]), 0);
      chk($sformatf("rst_out_sat_%0d", k), int'(os[k]), 0);
    end
    @(posedge clk); #3 rst = 1'b0;

    // Directed cases, including clipping, ReLU and floor-shift corners.
    send(8'd3, 8'd4, 8'd5, 8'd6, 8'd0);
    drain();
    send(8'd100, 8'd100, 8'd100, 8'd100, 8'd0);
    send(8'h80, 8'h80, 8'd127, 8'd127, 8'd0);
    send(8'd3, -8'sd4, 8'd5, 8'd6, 8'd0);
    send(8'd16, 8'hff, 8'd16, 8'd1, 8'd0);
    send(-8'sd17, 8'd0, 8'd1, 8'd0, 8'd0);
    send(8'd0, 8'd0, 8'd0, 8'd0, -8'sd16);
    send(8'h80, 8'h80, 8'h80, 8'h80, 8'h80);
    send(8'h80, 8'd0, 8'h80, 8'd0, 8'd0);
    drain();

    // Backpressure with a pending in_valid held through the stall.
    out_ready = 1'b0;
    send(8'd7, 8'd9, 8'hfd, 8'd2, 8'd5);
    @(posedge clk); #1;
    in_data = {8'd2, 8'd6}; in_weight = {8'd3, 8'd4}; in_bias = 8'd1; in_valid = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("stall_in_ready", int'(rdy[0]), 0);
    end
    chk("stall_out_valid", int'(ov[0]), 1);
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("release_in_ready", int'(rdy[0]), 1);
    chk("release_out_valid", int'(ov[0]), 0);
    @(posedge clk); #1;
    chk("pending_accepted", int'(rdy[0]), 0);
    in_valid = 1'b0;
    drain();

    // Asynchronous reset in the middle of an accumulation.
    @(posedge clk); #1;
    in_data = {8'd50, 8'd50}; in_weight = {8'd50, 8'd50}; in_bias = 8'd0; in_valid = 1'b1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (rdy[0]) got = 1;
    end
    if (!got) chk("rst_op_accept", 0, 1);
    @(posedge clk); #1 in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("async_in_ready_%0d", k), int'(rdy[k]), 1);
      chk($sformatf("async_out_valid_%0d", k), int'(ov[k]), 0);
      chk($sformatf("async_out_data_%0d", k), int'(od[k]), 0);
    end
    q.delete();
    seen = 0;
    @(posedge clk); #3 rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("no_stale_result", int'(ov[0]), 0);
    send(8'd1, 8'd1, 8'd1, 8'd1, 8'd0);
    drain();

    // Randomised operands with random downstream backpressure.
    rand_rdy = 1;
    for (int n = 0; n < 60; n++)
      send(pick(), pick(), pick(), pick(), pick());
    @(posedge clk); #2;
    rand_rdy = 0;
    out_ready = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
